// File: rtl/prbs_lock_checker.sv
// PRBS checker: self-seeding acquisition, lock/loss FSM with windowed error tracking,
// two-stage mismatch/popcount pipeline and saturating error and loss counters.
module prbs_lock_checker #(
  parameter int NBITS       = 64,
  parameter int CNT_W       = 32,
  parameter int LOCK_CNT    = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  localparam int EBW        = $clog2(NBITS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       POLY_SEL,
  input  logic             INV,
  input  logic [NBITS-1:0] DATA_IN,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR_WORD,
  output logic [EBW-1:0]   ERR_BITS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] LOSS_CNT
);

  localparam logic ST_SEARCH = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam int CLEAN_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int BAD_W   = $clog2(UNLOCK_ERRS + 1);
  localparam int SUM_W   = ((CNT_W > EBW) ? CNT_W : EBW) + 1;

  localparam logic [CLEAN_W-1:0] LOCK_LAST = CLEAN_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_END   = WIN_W'(WINDOW);
  localparam logic [BAD_W-1:0]   BAD_LIMIT = BAD_W'(UNLOCK_ERRS);
  localparam logic [SUM_W-1:0]   CNT_MAX   = SUM_W'({CNT_W{1'b1}});

  logic               state;
  logic [30:0]        lfsr;
  logic [30:0]        lfsr_nxt;
  logic [NBITS-1:0]   rx;
  logic [NBITS-1:0]   mis;
  logic [NBITS-1:0]   mis_q;
  logic [2:0]         poly_q;
  logic               inv_q;
  logic               sel_change;
  logic [4:0]         len_idx;
  logic [4:0]         tap_idx;
  logic [CLEAN_W-1:0] clean_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_nxt;
  logic [BAD_W-1:0]   bad_cnt;
  logic [BAD_W-1:0]   bad_nxt;
  logic               word_clean;
  logic               word_bad;
  logic               lose;
  logic [SUM_W-1:0]   err_sum;

  function automatic logic [EBW-1:0] popcount(input logic [NBITS-1:0] v);
    logic [EBW-1:0] c;
    c = '0;
    for (int i = 0; i < NBITS; i++) c = c + EBW'(v[i]);
    return c;
  endfunction

  always_comb begin
    len_idx = 5'd30;
    tap_idx = 5'd27;
    case (POLY_SEL)
      3'd0: begin len_idx = 5'd6;  tap_idx = 5'd5;  end
      3'd1: begin len_idx = 5'd8;  tap_idx = 5'd4;  end
      3'd2: begin len_idx = 5'd14; tap_idx = 5'd13; end
      3'd3: begin len_idx = 5'd22; tap_idx = 5'd17; end
      default: begin len_idx = 5'd30; tap_idx = 5'd27; end
    endcase
  end

  assign rx         = INV ? ~DATA_IN : DATA_IN;
  assign sel_change = (POLY_SEL != poly_q) || (INV != inv_q);

  // Walk the word oldest bit first; the LFSR seeds from data while searching, free-runs once locked.
  always_comb begin
    logic [30:0] s;
    logic        p;
    s   = lfsr;
    p   = 1'b0;
    mis = '0;
    for (int i = 0; i < NBITS; i++) begin
      p      = s[tap_idx] ^ s[len_idx];
      mis[i] = p ^ rx[i];
      s      = {s[29:0], (state == ST_LOCKED) ? p : rx[i]};
    end
    lfsr_nxt = s;
  end

  assign word_clean = (mis == '0) && (rx != '0);
  assign word_bad   = |mis;
  assign win_nxt    = win_cnt + WIN_W'(1);
  assign bad_nxt    = bad_cnt + BAD_W'(word_bad);
  assign lose       = EN && !sel_change && (state == ST_LOCKED) && (bad_nxt == BAD_LIMIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_SEARCH;
      lfsr      <= '1;
      clean_cnt <= '0;
      win_cnt   <= '0;
      bad_cnt   <= '0;
      poly_q    <= POLY_SEL;
      inv_q     <= INV;
    end else begin
      poly_q <= POLY_SEL;
      inv_q  <= INV;
      if (sel_change) begin
        state     <= ST_SEARCH;
        lfsr      <= '1;
        clean_cnt <= '0;
        win_cnt   <= '0;
        bad_cnt   <= '0;
      end else if (EN) begin
        lfsr <= lfsr_nxt;
        if (state == ST_SEARCH) begin
          if (!word_clean) begin
            clean_cnt <= '0;
          end else if (clean_cnt == LOCK_LAST) begin
            state     <= ST_LOCKED;
            clean_cnt <= '0;
            win_cnt   <= '0;
            bad_cnt   <= '0;
          end else begin
            clean_cnt <= clean_cnt + CLEAN_W'(1);
          end
        end else if (lose) begin
          state     <= ST_SEARCH;
          clean_cnt <= '0;
          win_cnt   <= '0;
          bad_cnt   <= '0;
        end else if (win_nxt == WIN_END) begin
          win_cnt <= '0;
          bad_cnt <= '0;
        end else begin
          win_cnt <= win_nxt;
          bad_cnt <= bad_nxt;
        end
      end
    end
  end

  assign LOCKED = (state == ST_LOCKED);

  // The word coinciding with a polynomial/inversion change is not reported.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mis_q    <= '0;
      ERR_WORD <= 1'b0;
      ERR_BITS <= '0;
    end else begin
      mis_q    <= (EN && (state == ST_LOCKED) && !sel_change) ? mis : '0;
      ERR_WORD <= |mis_q;
      ERR_BITS <= popcount(mis_q);
    end
  end

  assign err_sum = SUM_W'(ERR_CNT) + SUM_W'(ERR_BITS);

  always_ff @(posedge CLK) begin
    if (RST || CLR_CNT) begin
      ERR_CNT  <= '0;
      LOSS_CNT <= '0;
    end else begin
      ERR_CNT <= (err_sum > CNT_MAX) ? '1 : err_sum[CNT_W-1:0];
      if (lose && (LOSS_CNT != '1)) LOSS_CNT <= LOSS_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Directed bench for prbs_lock_checker: reference PRBS generator drives acquisition, error
// injection, windowed loss of lock, saturation, clear priority, reselect and reset cases.
module tb_prbs_lock_checker;

  localparam int NBITS = 64;
  localparam int CNT_W = 8;
  localparam int EBW   = $clog2(NBITS + 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic [2:0]       POLY_SEL;
  logic             INV;
  logic [NBITS-1:0] DATA_IN;
  logic             CLR_CNT;
  logic             LOCKED;
  logic             ERR_WORD;
  logic [EBW-1:0]   ERR_BITS;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] LOSS_CNT;

  int checks   = 0;
  int failures = 0;

  logic [30:0] gst;
  int          glen;
  int          gtap;

  prbs_lock_checker #(
    .NBITS(NBITS), .CNT_W(CNT_W), .LOCK_CNT(16), .WINDOW(64), .UNLOCK_ERRS(8)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .POLY_SEL(POLY_SEL), .INV(INV), .DATA_IN(DATA_IN),
    .CLR_CNT(CLR_CNT), .LOCKED(LOCKED), .ERR_WORD(ERR_WORD), .ERR_BITS(ERR_BITS),
    .ERR_CNT(ERR_CNT), .LOSS_CNT(LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  task check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task gen_reset(input int len, input int tap);
    gst  = '1;
    glen = len;
    gtap = tap;
  endtask

  // Reference generator: out = s[tap]^s[len], fed back into the register, oldest bit in LSB.
  task gen_word(output logic [NBITS-1:0] w);
    logic b;
    for (int i = 0; i < NBITS; i++) begin
      b    = gst[gtap-1] ^ gst[glen-1];
      w[i] = b;
      gst  = {gst[29:0], b};
    end
  endtask

  task apply_stimulus(input logic [NBITS-1:0] d, input logic en, input logic clr);
    @(negedge CLK);
    DATA_IN = d;
    EN      = en;
    CLR_CNT = clr;
    @(posedge CLK);
    #1;
  endtask

  task send_clean(input int n, input logic invert);
    logic [NBITS-1:0] w;
    for (int k = 0; k < n; k++) begin
      gen_word(w);
      apply_stimulus(invert ? ~w : w, 1'b1, 1'b0);
    end
  endtask

  task send_flipped(input logic [NBITS-1:0] mask);
    logic [NBITS-1:0] w;
    gen_word(w);
    apply_stimulus(w ^ mask, 1'b1, 1'b0);
  endtask

  task idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NBITS-1:0] w;
    logic             flag;
    int               pulses;

    RST = 1'b1; EN = 1'b0; INV = 1'b0; CLR_CNT = 1'b0; POLY_SEL = 3'd4; DATA_IN = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_locked",   LOCKED,   0);
    check_output("rst_err_word", ERR_WORD, 0);
    check_output("rst_err_bits", ERR_BITS, 0);
    check_output("rst_err_cnt",  ERR_CNT,  0);
    check_output("rst_loss_cnt", LOSS_CNT, 0);

    // PRBS31 acquisition and a long clean run with EN gaps.
    RST = 1'b0;
    gen_reset(31, 28);
    send_clean(15, 1'b0);
    check_output("prbs31_prelock", LOCKED, 0);
    send_clean(1, 1'b0);
    check_output("prbs31_lock", LOCKED, 1);
    pulses = 0;
    for (int k = 0; k < 10000; k++) begin
      send_clean(1, 1'b0);
      pulses += int'(ERR_WORD);
      if (k % 1000 == 500) idle(3);
    end
    idle(2);
    check_output("prbs31_no_pulses", pulses, 0);
    check_output("prbs31_err_cnt", ERR_CNT, 0);
    check_output("prbs31_still_locked", LOCKED, 1);

    // Reselect PRBS7 and inject 1-bit and 3-bit errors.
    POLY_SEL = 3'd0;
    idle(1);
    check_output("sel_change_unlock", LOCKED, 0);
    check_output("sel_change_no_loss", LOSS_CNT, 0);
    gen_reset(7, 6);
    send_clean(15, 1'b0);
    check_output("prbs7_prelock", LOCKED, 0);
    send_clean(1, 1'b0);
    check_output("prbs7_lock", LOCKED, 1);
    send_flipped(64'h20);
    check_output("err_word_latency", ERR_WORD, 0);
    send_clean(1, 1'b0);
    check_output("err_word_1", ERR_WORD, 1);
    check_output("err_bits_1", ERR_BITS, 1);
    send_flipped(64'h8000_0000_0000_0401);
    check_output("err_cnt_1", ERR_CNT, 1);
    send_clean(1, 1'b0);
    check_output("err_word_3", ERR_WORD, 1);
    check_output("err_bits_3", ERR_BITS, 3);
    send_clean(1, 1'b0);
    check_output("err_cnt_4", ERR_CNT, 4);
    check_output("err_word_clear", ERR_WORD, 0);
    check_output("prbs7_locked_after_errs", LOCKED, 1);

    // Finish the current window, then 8 errored words in a fresh window.
    send_clean(59, 1'b0);
    for (int k = 0; k < 7; k++) begin
      send_flipped(64'h1 << k);
      send_clean(1, 1'b0);
    end
    check_output("window_reset_keeps_lock", LOCKED, 1);
    send_flipped(64'h1);
    check_output("loss_unlock", LOCKED, 0);
    check_output("loss_cnt_1", LOSS_CNT, 1);
    idle(2);
    check_output("err_cnt_12", ERR_CNT, 12);
    send_clean(15, 1'b0);
    check_output("relock_pre", LOCKED, 0);
    send_clean(1, 1'b0);
    check_output("relock", LOCKED, 1);

    // All-bit errors: saturation, then clear coinciding with an update.
    send_clean(6, 1'b1);
    check_output("err_cnt_saturate", ERR_CNT, 255);
    check_output("sat_still_locked", LOCKED, 1);
    gen_word(w);
    apply_stimulus(~w, 1'b1, 1'b1);
    check_output("clr_priority_err", ERR_CNT, 0);
    check_output("clr_priority_loss", LOSS_CNT, 0);
    send_clean(1, 1'b1);
    check_output("all_err_unlock", LOCKED, 0);
    check_output("all_err_loss_cnt", LOSS_CNT, 1);
    check_output("err_cnt_after_clr", ERR_CNT, 64);
    idle(2);
    check_output("err_cnt_drain", ERR_CNT, 192);

    // All-zero data never locks; inverted PRBS15 with INV=1 does.
    flag = 1'b0;
    for (int p = 0; p < 5; p++) begin
      POLY_SEL = 3'(p);
      for (int k = 0; k < 200; k++) begin
        apply_stimulus('0, 1'b1, 1'b0);
        flag |= LOCKED;
      end
    end
    check_output("zeros_never_lock", flag, 0);
    POLY_SEL = 3'd2;
    INV      = 1'b1;
    idle(1);
    gen_reset(15, 14);
    send_clean(15, 1'b1);
    check_output("inv15_prelock", LOCKED, 0);
    send_clean(1, 1'b1);
    check_output("inv15_lock", LOCKED, 1);
    check_output("search_no_count", ERR_CNT, 192);

    // Reselect 2->3 while locked, then reset with an error in the pipeline.
    POLY_SEL = 3'd3;
    send_clean(1, 1'b1);
    check_output("sel_2to3_unlock", LOCKED, 0);
    check_output("sel_2to3_loss_same", LOSS_CNT, 1);
    gen_reset(23, 18);
    send_clean(16, 1'b1);
    check_output("prbs23_lock", LOCKED, 1);
    send_clean(1, 1'b0);
    RST = 1'b1;
    send_clean(1, 1'b1);
    check_output("midrst_locked",   LOCKED,   0);
    check_output("midrst_err_word", ERR_WORD, 0);
    check_output("midrst_err_bits", ERR_BITS, 0);
    check_output("midrst_err_cnt",  ERR_CNT,  0);
    check_output("midrst_loss_cnt", LOSS_CNT, 0);
    RST = 1'b0;
    idle(2);
    check_output("flush_err_cnt",  ERR_CNT,  0);
    check_output("flush_err_word", ERR_WORD, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
